// File: rtl/pll_reconf_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: the FSM state
// encoding and the default sizing constants.
package pll_reconf_pkg;

  localparam int DEF_SCAN_CHAIN_LENGTH = 144;
  localparam int DEF_ROM_LATENCY       = 2;
  localparam int DEF_ADDR_WIDTH        = 8;
  localparam int DEF_TIMEOUT_CYCLES    = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WAIT_RECONF,
    ST_UPDATE,
    ST_WAIT_DONE
  } state_e;

endpackage

// File: rtl/pll_scan_shifter.sv
// Delays the ROM read strobe by the ROM latency so that each returning rom_q
// bit is registered onto scandata together with scanclkena.
module pll_scan_shifter
  import pll_reconf_pkg::*;
#(
  parameter int ROM_LATENCY = DEF_ROM_LATENCY
) (
  input  logic clock,
  input  logic reset_n,
  input  logic rd_ena_i,
  input  logic rom_q_i,
  output logic scanclkena_o,
  output logic scandata_o,
  output logic pipe_empty_o
);

  logic [ROM_LATENCY-1:0] vld_q;
  logic [ROM_LATENCY:0]   vld_pipe;
  logic                   scanclkena_q;
  logic                   scandata_q;

  // Stage 0 is the strobe itself; the top stage lines up with rom_q.
  assign vld_pipe = {vld_q, rd_ena_i};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q        <= '0;
      scanclkena_q <= 1'b0;
      scandata_q   <= 1'b0;
    end else begin
      vld_q        <= vld_pipe[ROM_LATENCY-1:0];
      scanclkena_q <= vld_q[ROM_LATENCY-1];
      scandata_q   <= vld_q[ROM_LATENCY-1] & rom_q_i;
    end
  end

  assign scanclkena_o = scanclkena_q;
  assign scandata_o   = scandata_q;
  assign pipe_empty_o = ~|vld_q;

endmodule

// File: rtl/pll_reconf_ctrl.sv
// PLL dynamic reconfiguration sequencer: reads the serial config ROM, shifts
// the bits into the PLL scan chain, issues configupdate and waits for scandone.
module pll_reconf_ctrl
  import pll_reconf_pkg::*;
#(
  parameter int SCAN_CHAIN_LENGTH = DEF_SCAN_CHAIN_LENGTH,
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int ROM_LATENCY       = DEF_ROM_LATENCY,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  trigger_read,
  input  logic                  reconfig,
  input  logic                  rom_q,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_read_ena,
  output logic                  busy,
  output logic                  scanclkena,
  output logic                  scandata,
  output logic                  configupdate,
  input  logic                  scandone,
  output logic                  reconf_error
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SCAN_CHAIN_LENGTH - 1);
  localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  rd_q, rd_d;
  logic                  cu_q, cu_d;
  logic                  err_q, err_d;
  logic                  rcfg_q, rcfg_d;
  logic                  busy_q;
  logic                  pipe_empty;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    cu_d    = 1'b0;
    err_d   = err_q;
    rcfg_d  = rcfg_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        rcfg_d = 1'b0;
        if (trigger_read) begin
          state_d = ST_READ;
          addr_d  = '0;
          rd_d    = 1'b1;
          err_d   = 1'b0;
        end
      end
      ST_READ: begin
        rcfg_d = rcfg_q | reconfig;
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
          addr_d  = '0;
          rd_d    = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        // Empty pipe here means the final bit is on scandata this cycle.
        rcfg_d = rcfg_q | reconfig;
        if (pipe_empty) state_d = ST_WAIT_RECONF;
      end
      ST_WAIT_RECONF: begin
        if (rcfg_q | reconfig) begin
          state_d = ST_UPDATE;
          cu_d    = 1'b1;
          rcfg_d  = 1'b0;
        end
      end
      ST_UPDATE: begin
        state_d = ST_WAIT_DONE;
        tmo_d   = '0;
      end
      ST_WAIT_DONE: begin
        if (scandone) begin
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      cu_q    <= 1'b0;
      err_q   <= 1'b0;
      rcfg_q  <= 1'b0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      cu_q    <= cu_d;
      err_q   <= err_d;
      rcfg_q  <= rcfg_d;
      tmo_q   <= tmo_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  pll_scan_shifter #(
    .ROM_LATENCY (ROM_LATENCY)
  ) u_shift (
    .clock        (clock),
    .reset_n      (reset_n),
    .rd_ena_i     (rd_q),
    .rom_q_i      (rom_q),
    .scanclkena_o (scanclkena),
    .scandata_o   (scandata),
    .pipe_empty_o (pipe_empty)
  );

  assign rom_address  = addr_q;
  assign rom_read_ena = rd_q;
  assign busy         = busy_q;
  assign configupdate = cu_q;
  assign reconf_error = err_q;

endmodule

// File: tb/tb_pll_reconf_ctrl.sv
// Randomized bench for pll_reconf_ctrl: a cycle-window model predicts every
// output from the trigger, reconfig and scandone times it has seen.
module tb_pll_reconf_ctrl;
  localparam int N = 144, L = 2, TMO = 1024, AW = 8;

  logic clock = 1'b1, reset_n = 1'b1;
  logic trigger_read = 1'b0, reconfig = 1'b0, rom_q = 1'b0, scandone = 1'b0;
  logic [AW-1:0] rom_address;
  logic rom_read_ena, busy, scanclkena, scandata, configupdate, reconf_error;

  int errors = 0, checks = 0, cyc = 0;
  bit pat [256];
  // model: trigger cycle, first reconfig, update cycle, cycle busy drops
  int t0 = -1, r_c = -1, u_c = -1, end_c = -1;
  bit m_err = 1'b0;
  bit pin1 = 1'b0;
  int cu_cnt = 0, cu_cyc = -1, err_rise = -1;
  logic err_prev = 1'b0;
  logic [AW-1:0] a_now = '0, a_prev = '0;

  pll_reconf_ctrl #(
    .SCAN_CHAIN_LENGTH(N), .ADDR_WIDTH(AW), .ROM_LATENCY(L), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .trigger_read(trigger_read), .reconfig(reconfig),
    .rom_q(rom_q), .rom_address(rom_address), .rom_read_ena(rom_read_ena), .busy(busy),
    .scanclkena(scanclkena), .scandata(scandata), .configupdate(configupdate),
    .scandone(scandone), .reconf_error(reconf_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Compare DUT against the model, then advance the model with this cycle's inputs.
  always @(negedge clock) begin
    bit e_rd, e_sce, e_sd, e_cu, e_busy;
    int e_addr;
    e_rd = 0; e_sce = 0; e_sd = 0; e_cu = 0; e_busy = 0; e_addr = 0;
    if (!reset_n) begin
      t0 = -1; r_c = -1; u_c = -1; end_c = -1; m_err = 1'b0;
    end else if (t0 >= 0) begin
      e_rd = (cyc >= t0 + 1) && (cyc <= t0 + N);
      if (e_rd) e_addr = cyc - t0 - 1;
      e_sce = (cyc >= t0 + L + 2) && (cyc <= t0 + N + L + 1);
      if (e_sce) e_sd = pat[cyc - t0 - L - 2];
      e_cu = (u_c >= 0) && (cyc == u_c);
      e_busy = (cyc >= t0 + 1) && (end_c < 0 || cyc < end_c);
    end
    chk("rom_address", rom_address, e_addr);
    chk("rom_read_ena", rom_read_ena, e_rd);
    chk("scanclkena", scanclkena, e_sce);
    chk("scandata", scandata, e_sd);
    chk("configupdate", configupdate, e_cu);
    chk("busy", busy, e_busy);
    chk("reconf_error", reconf_error, m_err);
    if (pin1) begin
      case (cyc)
        11:  chk("pin_addr_first", {rom_read_ena, rom_address}, 32'h100);
        154: chk("pin_addr_last", {rom_read_ena, rom_address}, 32'h18f);
        155: chk("pin_rd_fall", rom_read_ena, 0);
        13:  chk("pin_sce_before", scanclkena, 0);
        14:  chk("pin_sce_rise", scanclkena, 1);
        157: chk("pin_sce_last", scanclkena, 1);
        158: chk("pin_sce_fall", scanclkena, 0);
        159: chk("pin_cu", configupdate, 1);
        default: ;
      endcase
    end
    if (configupdate) begin cu_cnt++; cu_cyc = cyc; end
    if (reconf_error && !err_prev) err_rise = cyc;
    err_prev = reconf_error;
    if (reset_n) begin
      if (!e_busy && trigger_read) begin
        t0 = cyc; r_c = -1; u_c = -1; end_c = -1; m_err = 1'b0;
      end else if (t0 >= 0 && end_c < 0) begin
        if (r_c < 0 && reconfig && cyc > t0) r_c = cyc;
        if (u_c < 0 && r_c >= 0) u_c = (r_c + 1 > t0 + N + L + 3) ? r_c + 1 : t0 + N + L + 3;
        if (u_c >= 0 && cyc >= u_c + 1) begin
          if (scandone) end_c = cyc + 1;
          else if (cyc == u_c + TMO) begin end_c = cyc + 1; m_err = 1'b1; end
        end
      end
    end
  end

  // One clock; the ROM model returns the bit addressed two cycles earlier.
  task automatic tick();
    @(negedge clock);
    a_now = rom_address;
    @(posedge clock);
    #1;
    rom_q = pat[a_prev];
    a_prev = a_now;
    cyc++;
  endtask

  task automatic run_txn(input int rc_at, input int sd_at, input bit done);
    int t, g;
    trigger_read = 1'b1; t = cyc; tick(); trigger_read = 1'b0;
    while (cyc < t + rc_at) begin
      if ($urandom_range(0, 15) == 0) trigger_read = 1'b1;
      if ($urandom_range(0, 15) == 0) scandone = 1'b1;
      tick();
      trigger_read = 1'b0; scandone = 1'b0;
    end
    reconfig = 1'b1; tick(); reconfig = 1'b0;
    g = 0;
    while (u_c < 0 && g < 400) begin tick(); g++; end
    if (u_c < 0) begin
      checks++; errors++;
      $display("FAIL update_wait cyc=%0d got=none want=update scheduled", cyc);
      return;
    end
    if (done) begin
      while (cyc < u_c + sd_at) tick();
      scandone = 1'b1; tick(); scandone = 1'b0;
    end else begin
      while (cyc <= u_c + TMO + 1) tick();
    end
    repeat (3) tick();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 256; i++) pat[i] = (i % 2 == 1);
    #1 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Alternating chain, trigger at 10, ignored trigger at 50, reconfig at T+N+4.
    while (cyc < 10) tick();
    pin1 = 1'b1; cu_cnt = 0;
    trigger_read = 1'b1; tick(); trigger_read = 1'b0;
    while (cyc < 50) tick();
    trigger_read = 1'b1; tick(); trigger_read = 1'b0;
    while (cyc < 158) tick();
    reconfig = 1'b1; tick(); reconfig = 1'b0;
    while (cyc < 163) tick();
    scandone = 1'b1; tick(); scandone = 1'b0;
    repeat (3) tick();
    pin1 = 1'b0;
    chk("pin_cu_count", cu_cnt, 1);
    chk("pin_busy_after_done", busy, 0);

    // reconfig during DRAIN is held until WAIT_RECONF.
    for (int i = 0; i < N; i++) pat[i] = 1'($urandom);
    t = cyc;
    run_txn(N + 2, 3, 1'b1);
    chk("pin_drain_cu", cu_cyc - t, N + L + 3);

    // scandone never arrives.
    run_txn(N + 4, 0, 1'b0);
    chk("pin_err_latency", err_rise - cu_cyc, TMO + 1);
    chk("pin_err_set", {busy, reconf_error}, 32'h1);
    run_txn(N + 4, 2, 1'b1);
    chk("pin_err_cleared", reconf_error, 0);

    // Reset at address 70.
    cu_cnt = 0;
    trigger_read = 1'b1; t = cyc; tick(); trigger_read = 1'b0;
    while (cyc < t + 71) tick();
    chk("pin_addr70", rom_address, 70);
    reset_n = 1'b0;
    #1;
    chk("rst_addr", rom_address, 0);
    chk("rst_rd", rom_read_ena, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sce", scanclkena, 0);
    chk("rst_sd", scandata, 0);
    chk("rst_cu", configupdate, 0);
    chk("rst_err", reconf_error, 0);
    repeat (2) tick();
    reconfig = 1'b1; tick(); reconfig = 1'b0;
    reset_n = 1'b1;
    repeat (200) tick();
    chk("pin_no_cu_after_reset", cu_cnt, 0);
    run_txn(N + 6, 1, 1'b1);

    // reconfig while idle does nothing.
    reconfig = 1'b1; tick(); reconfig = 1'b0;
    repeat (6) tick();
    chk("pin_idle_reconfig", {busy, configupdate}, 0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) pat[i] = 1'($urandom);
      run_txn($urandom_range(2, N + L + 12), $urandom_range(0, 15), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pll_reconf_ctrl.md
# pll_reconf_ctrl

Sequencer that performs PLL dynamic reconfiguration as the reader side of the reconfiguration ROM interface. On a ROM trigger it walks the ROM addresses, takes the serial configuration bits, and shifts them into the PLL scan chain. It then issues the config update and waits for scan completion. It sits between `pll_reconf_rom` and the PLL's scan-chain pins, and reports busy back to the ROM so that mode changes are deferred while a reconfiguration is in progress.

## Interface
Parameters:
- `SCAN_CHAIN_LENGTH`, default 144: number of scan bits; ROM addresses 0..N-1.
- `ADDR_WIDTH`, default 8: ROM address width; must satisfy 2^ADDR_WIDTH ≥ `SCAN_CHAIN_LENGTH`.
- `ROM_LATENCY`, default 2: clocks from address/read_ena to valid `rom_q`.
- `TIMEOUT_CYCLES`, default 1024: maximum wait for `scandone`.

Ports:
- `clock` input 1: single clock; the PLL `scanclk` is tied to this clock at top level.
- `reset_n` input 1: asynchronous, active-low reset.
- `trigger_read` input 1: one-cycle start pulse from the ROM.
- `reconfig` input 1: one-cycle pulse from the ROM after `read_ena` falls.
- `rom_q` input 1: serial configuration bit from the ROM.
- `rom_address` output ADDR_WIDTH: ROM bit address.
- `rom_read_ena` output 1: ROM read strobe.
- `busy` output 1: reconfiguration in progress; drives the ROM's `pll_reconf_busy`.
- `scanclkena` output 1: PLL scan clock enable.
- `scandata` output 1: PLL scan data.
- `configupdate` output 1: PLL config update pulse.
- `scandone` input 1: PLL scan-complete flag, synchronous to `clock`.
- `reconf_error` output 1: sticky timeout flag.

## Operation
- States:
  - IDLE
  - READ: issue addresses.
  - DRAIN: flush ROM latency.
  - WAIT_RECONF
  - UPDATE
  - WAIT_DONE
- IDLE → READ on `trigger_read`. A `trigger_read` in any other state is ignored. A `reconfig` seen in IDLE is ignored.
- READ:
  - `rom_read_ena`=1; `rom_address` runs 0, 1, … `SCAN_CHAIN_LENGTH`-1, one address per clock.
  - After the last address: `rom_read_ena`=0, `rom_address`=0, go to DRAIN.
- Shift path:
  - `rom_q` is registered onto `scandata` together with `scanclkena`=1.
  - The bit for address k appears on `scandata` exactly `ROM_LATENCY`+1 clocks after address k is issued.
  - Bits are shifted in address order, address 0 first.
  - `scanclkena` stays high for exactly `SCAN_CHAIN_LENGTH` contiguous cycles.
- DRAIN → WAIT_RECONF when the last bit has been shifted (`scanclkena` falls).
- `reconfig` latch:
  - A `reconfig` pulse arriving in READ, DRAIN or WAIT_RECONF is latched.
  - WAIT_RECONF → UPDATE on the latched or live `reconfig`.
- UPDATE: `configupdate`=1 for one cycle, then go to WAIT_DONE and clear the timeout counter.
- WAIT_DONE:
  - → IDLE when `scandone` is high.
  - If the timeout counter reaches `TIMEOUT_CYCLES`-1: set `reconf_error`, go to IDLE.
- `reconf_error` clears on the next accepted `trigger_read`.
- `busy`=1 in every state except IDLE.
- Reset (at assertion or mid-operation): state → IDLE and every output → 0. A partially shifted chain is never followed by `configupdate`.

## Timing
- Reset values: `rom_address`=0, `rom_read_ena`=0, `busy`=0, `scanclkena`=0, `scandata`=0, `configupdate`=0, `reconf_error`=0.
- `trigger_read` at cycle T:
  - `busy`=1, `rom_read_ena`=1 and `rom_address`=0 from T+1.
  - Last address at T+N (N = `SCAN_CHAIN_LENGTH`).
  - `rom_read_ena`=0 at T+N+1.
- `scanclkena` is high from T+`ROM_LATENCY`+2 through T+N+`ROM_LATENCY`+1.
- `configupdate` is asserted the cycle after the state is WAIT_RECONF and `reconfig` has been seen. With the standard ROM, `reconfig` arrives at about T+N+4.
- `busy` falls the cycle after `scandone` is sampled high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `pll_reconf_pkg`: state enum and default parameter constants (chain length 144, ROM latency 2).
- One sub-module, `pll_scan_shifter`: the `ROM_LATENCY`-deep valid pipeline that aligns `rom_q` with `scanclkena`/`scandata`.
- The FSM, address counter, `reconfig` latch and timeout counter live in `pll_reconf_ctrl`.

## Test plan
- Chain of 144 alternating bits from a ROM model with latency 2; `trigger_read` at cycle 10:
  - `rom_address` 0..143 on cycles 11..154.
  - `scanclkena` high on cycles 14..157, `scandata` reproducing the pattern.
  - `configupdate` pulse once; `busy` low after `scandone`.
- `reconfig` pulse arriving during DRAIN → latched; `configupdate` issued on entering WAIT_RECONF.
- Second `trigger_read` at cycle 50 while busy → ignored; address sequence undisturbed.
- `scandone` held low → `reconf_error`=1 at 1024 cycles into WAIT_DONE; state IDLE; next trigger clears it.
- `reset_n` low at address 70 → all outputs 0 immediately; no `configupdate`; a new trigger restarts from address 0.
- `reconfig` pulse while IDLE → no output activity, `busy` stays 0.
